scn_buf: RTL and testbench

Parametrised screen buffer for the static-screen display path: a simple dual-port character memory sized COLS×ROWS. It has a display read port, a CPU-side write port with acknowledge, hardware row scrolling and a self-timed clear engine. It sits between the Wishbone screen-register front end (write side) and the character/pixel generator (read side), and replaces the fixed 13-bit ROM-style screen memory.

---
 rtl/scn_buf.sv | 108 ++++++++++
 tb/tb_scn_buf.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scn_buf.sv
// Character screen buffer: COLS x ROWS dual-port memory with a 1-cycle display read,
// an acknowledged CPU write port, row scrolling by address offset and a self-timed clear.
module scn_buf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 60,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned ROW_W     = 6,
  parameter string       INIT_FILE = ""
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              scroll_set,
  input  logic [ROW_W-1:0]  scroll_row,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] fill,
  output logic              busy
);

  localparam int unsigned       DEPTH   = COLS * ROWS;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] rd_phys_p0;
  logic [ADDR_W-1:0] wr_phys_p0;
  logic              wr_take_p0;

  function automatic logic in_range(input logic [ADDR_W-1:0] la);
    return ({1'b0, la} < DEPTH_X);
  endfunction

  // Both operands are below DEPTH, so a single conditional subtract wraps the sum.
  function automatic logic [ADDR_W-1:0] to_phys(input logic [ADDR_W-1:0] la,
                                                input logic [ADDR_W-1:0] off);
    logic [ADDR_W:0] sum;
    sum = {1'b0, la} + {1'b0, off};
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[ADDR_W-1:0];
  endfunction

  // Stage p0: address translation and write acceptance (clear request beats a write)
  always_comb begin
    rd_phys_p0 = to_phys(addr, offset);
    wr_phys_p0 = to_phys(wr_addr, offset);
    wr_take_p0 = (state == IDLE) && !clr_req && wr_en && !wr_ack;
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      wr_ack     <= 1'b0;
      offset     <= '0;
      data_valid <= 1'b0;
    end else begin
      wr_ack     <= wr_take_p0;
      data_valid <= read;
      if (scroll_set && (32'(scroll_row) < ROWS))
        offset <= ADDR_W'(scroll_row) * COLS_A;
      if (state == IDLE) begin
        if (clr_req) begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

  // Stage p1: registered read data, read-before-write on a shared address
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n)
      data_out <= '0;
    else if (read)
      data_out <= in_range(addr) ? mem[rd_phys_p0] : '0;
  end

  always_ff @(posedge sck) begin
    if (state == CLEAR)
      mem[cnt] <= fill;
    else if (wr_take_p0 && in_range(wr_addr))
      mem[wr_phys_p0] <= wr_data;
  end

endmodule

// File: tb/tb_scn_buf.sv
// Bench for scn_buf: random stimulus checked against a flat-array screen model
// with modulo-based scroll translation.
module tb_scn_buf;

  localparam int DEPTH = 4800;
  localparam int COLS  = 80;

  logic        sck = 1'b0;
  logic        rst_n = 1'b1;
  logic        read = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        wr_en = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        scroll_set = 1'b0;
  logic [5:0]  scroll_row = '0;
  logic        clr_req = 1'b0;
  logic [7:0]  fill = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [DEPTH];
  int scroll_m = 0;

  scn_buf dut (
    .sck(sck), .rst_n(rst_n), .read(read), .addr(addr),
    .data_out(data_out), .data_valid(data_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .scroll_set(scroll_set), .scroll_row(scroll_row),
    .clr_req(clr_req), .fill(fill), .busy(busy)
  );

  always #5 sck = ~sck;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int phys(input int la);
    return (la + scroll_m * COLS) % DEPTH;
  endfunction

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 7 + 3) ^ (k >> 8));
  endfunction

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic do_read(input int a, output logic [7:0] d, output logic v);
    read = 1'b1;
    addr = 13'(a);
    tick();
    d = data_out;
    v = data_valid;
    read = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [7:0] d, output int acks, output int lat);
    wr_en = 1'b1;
    wr_addr = 13'(a);
    wr_data = d;
    acks = 0;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (wr_ack) begin
        acks++;
        if (lat < 0) lat = c;
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic set_scroll(input int r);
    scroll_set = 1'b1;
    scroll_row = 6'(r);
    tick();
    scroll_set = 1'b0;
    if (r < 60) scroll_m = r;
  endtask

  task automatic scan(output int bad, output int first, output logic [7:0] got, output logic [7:0] want);
    bad = 0;
    first = -1;
    got = '0;
    want = '0;
    read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      addr = 13'(i);
      tick();
      if (data_out !== model[phys(i)] || data_valid !== 1'b1) begin
        if (first < 0) begin
          first = i;
          got = data_out;
          want = model[phys(i)];
        end
        bad++;
      end
    end
    read = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pattern_clear();
    int busy_cnt;
    int ack_cnt;
    int bad, first;
    logic [7:0] got, want, d;
    logic v;
    clr_req = 1'b1;
    fill = pat(0);
    tick();
    clr_req = 1'b0;
    busy_cnt = busy ? 1 : 0;
    ack_cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      fill = pat(k);
      tick();
      if (busy) busy_cnt++;
      if (wr_ack) ack_cnt++;
    end
    for (int k = 0; k < DEPTH; k++) model[k] = pat(k);
    n_checks++; if (busy_cnt !== DEPTH) begin n_fail++; $display("FAIL clear_busy_len: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_end: got %b want 0", busy); end
    do_read(9, d, v);
    n_checks++; if (d !== pat(9) || v !== 1'b1) begin n_fail++; $display("FAIL read_word9: got %h/%b want %h/1", d, v, pat(9)); end
    tick();
    n_checks++; if (data_valid !== 1'b0 || data_out !== pat(9)) begin n_fail++; $display("FAIL read_idle_hold: got %h/%b want %h/0", data_out, data_valid, pat(9)); end
    scan(bad, first, got, want);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL pattern_scan: %0d bad, first %0d got %h want %h", bad, first, got, want); end
  endtask

  task automatic test_write();
    int acks, lat;
    logic [7:0] d;
    logic v;
    do_write(160, 8'h41, acks, lat);
    model[phys(160)] = 8'h41;
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL write_ack_count: got %0d want 1", acks); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL write_ack_latency: got %0d want 1", lat); end
    do_read(160, d, v);
    n_checks++; if (d !== 8'h41) begin n_fail++; $display("FAIL write_readback: got %h want 41", d); end
  endtask

  task automatic test_scroll();
    logic [7:0] d, exp;
    logic v;
    int a;
    scroll_set = 1'b1;
    scroll_row = 6'd2;
    read = 1'b1;
    addr = 13'd0;
    tick();
    scroll_set = 1'b0;
    read = 1'b0;
    n_checks++; if (data_out !== model[0]) begin n_fail++; $display("FAIL scroll_same_cycle: got %h want %h", data_out, model[0]); end
    scroll_m = 2;
    do_read(0, d, v);
    n_checks++; if (d !== 8'h41) begin n_fail++; $display("FAIL scroll_addr0: got %h want 41", d); end
    do_read(4700, d, v);
    n_checks++; if (d !== model[60]) begin n_fail++; $display("FAIL scroll_wrap4700: got %h want %h", d, model[60]); end
    set_scroll(60);
    do_read(0, d, v);
    n_checks++; if (d !== 8'h41) begin n_fail++; $display("FAIL scroll_ignore60: got %h want 41", d); end
    for (int n = 0; n < 4; n++) begin
      set_scroll($urandom_range(0, 59));
      a = $urandom_range(0, DEPTH - 1);
      exp = model[phys(a)];
      do_read(a, d, v);
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL scroll_random: row %0d addr %0d got %h want %h", scroll_m, a, d, exp); end
    end
    set_scroll(0);
  endtask

  task automatic test_back_to_back();
    int cur_a, ra, acks, last, rd_bad, gap_bad, cyc;
    int bad, first;
    logic [7:0] cur_d, exp, got, want;
    set_scroll($urandom_range(1, 59));
    cur_a = $urandom_range(0, DEPTH - 1);
    cur_d = 8'($urandom);
    acks = 0; last = 0; rd_bad = 0; gap_bad = 0; cyc = 0;
    wr_en = 1'b1;
    wr_addr = 13'(cur_a);
    wr_data = cur_d;
    while (acks < 40 && cyc < 200) begin
      cyc++;
      ra = ($urandom_range(0, 3) == 0) ? cur_a : $urandom_range(0, DEPTH - 1);
      read = 1'b1;
      addr = 13'(ra);
      exp = model[phys(ra)];
      tick();
      if (data_out !== exp) rd_bad++;
      if (wr_ack) begin
        model[phys(cur_a)] = cur_d;
        acks++;
        if ((acks == 1 && cyc != 1) || (acks > 1 && cyc - last != 2)) gap_bad++;
        last = cyc;
        cur_a = $urandom_range(0, DEPTH - 1);
        cur_d = 8'($urandom);
        wr_addr = 13'(cur_a);
        wr_data = cur_d;
      end
    end
    wr_en = 1'b0;
    read = 1'b0;
    tick();
    n_checks++; if (acks !== 40) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 40", acks); end
    n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL b2b_ack_spacing: %0d bad gaps, want 0", gap_bad); end
    n_checks++; if (rd_bad !== 0) begin n_fail++; $display("FAIL b2b_read_first: %0d bad reads, want 0", rd_bad); end
    scan(bad, first, got, want);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_scan: %0d bad, first %0d got %h want %h", bad, first, got, want); end
    set_scroll(0);
  endtask

  task automatic test_clear_with_write();
    int busy_cnt, ack_busy, ack_after;
    int bad, first;
    logic [7:0] got, want;
    clr_req = 1'b1;
    fill = 8'h20;
    wr_en = 1'b1;
    wr_addr = 13'd5;
    wr_data = 8'h7E;
    tick();
    clr_req = 1'b0;
    busy_cnt = busy ? 1 : 0;
    ack_busy = wr_ack ? 1 : 0;
    ack_after = 0;
    for (int c = 0; c < DEPTH + 10; c++) begin
      tick();
      if (busy) busy_cnt++;
      if (wr_ack) begin
        if (busy) ack_busy++;
        else ack_after++;
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = 8'h20;
    model[phys(5)] = 8'h7E;
    n_checks++; if (busy_cnt !== DEPTH) begin n_fail++; $display("FAIL clrwr_busy_len: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (ack_busy !== 0) begin n_fail++; $display("FAIL clrwr_ack_in_busy: got %0d want 0", ack_busy); end
    n_checks++; if (ack_after !== 1) begin n_fail++; $display("FAIL clrwr_ack_after: got %0d want 1", ack_after); end
    scan(bad, first, got, want);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clrwr_scan: %0d bad, first %0d got %h want %h", bad, first, got, want); end
  endtask

  task automatic test_out_of_range();
    int acks, lat, a;
    int bad, first;
    logic [7:0] d, got, want;
    logic v;
    do_read(5, d, v);
    n_checks++; if (d !== 8'h7E) begin n_fail++; $display("FAIL oor_pre_read: got %h want 7e", d); end
    do_read(7000, d, v);
    n_checks++; if (d !== 8'h00 || v !== 1'b1) begin n_fail++; $display("FAIL oor_read: got %h/%b want 00/1", d, v); end
    do_write(7000, 8'h99, acks, lat);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL oor_write_ack: got %0d want 1", acks); end
    a = $urandom_range(DEPTH, 8191);
    do_write(a, 8'($urandom), acks, lat);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL oor_rand_ack: addr %0d got %0d want 1", a, acks); end
    scan(bad, first, got, want);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL oor_scan: %0d bad, first %0d got %h want %h", bad, first, got, want); end
  endtask

  task automatic test_reset_mid_clear();
    int acks, lat;
    int bad, first;
    logic [7:0] d, got, want;
    logic v;
    do_write(99, 8'h11, acks, lat);
    model[phys(99)] = 8'h11;
    do_write(200, 8'h55, acks, lat);
    model[phys(200)] = 8'h55;
    set_scroll(3);
    clr_req = 1'b1;
    fill = 8'h20;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstclr_busy_async: got %b want 0", busy); end
    #2 rst_n = 1'b1;
    scroll_m = 0;
    for (int k = 0; k < 100; k++) model[k] = 8'h20;
    tick();
    n_checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL rstclr_idle: busy/valid got %b/%b want 0/0", busy, data_valid); end
    do_read(99, d, v);
    n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL rstclr_loc99: got %h want 20", d); end
    do_read(200, d, v);
    n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL rstclr_loc200: got %h want 55", d); end
    scan(bad, first, got, want);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstclr_scan: %0d bad, first %0d got %h want %h", bad, first, got, want); end
  endtask

  initial begin
    test_reset();
    test_pattern_clear();
    test_write();
    test_scroll();
    test_back_to_back();
    test_clear_with_write();
    test_out_of_range();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
